// File: rtl/copperv_wb_arbiter.sv
// copperv_wb_arbiter
//   Shares one classic single-beat Wishbone bus between the copperv
//   instruction-fetch master (inst_*) and the load/store master (data_*).
//   Round-robin on simultaneous requests, grant held for the owner's whole
//   cyc, and a per-beat stb-to-ack timeout that turns a hung slave into an err.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   inst_* / data_* (inputs)    master requests: cyc, stb, we, adr, dat_w, sel
//   inst_* / data_* (outputs)   master responses: ack, err, dat_r
//   bus_* (outputs)             shared bus request: cyc, stb, we, adr, dat_w, sel
//   bus_ack, bus_err, bus_dat_r slave response
//   grant                       {data,inst} one-hot owner, 00 when idle
//   timeout_pulse               one cycle when a beat is forced to err
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | no owner, bus_cyc low, arbitrating on the next edge
// GNT_INST | instruction master owns the bus until it drops cyc
// GNT_DATA | data master owns the bus until it drops cyc
module copperv_wb_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMER_WIDTH    = 9
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    inst_cyc,
  input  logic                    inst_stb,
  input  logic                    inst_we,
  input  logic [ADDR_WIDTH-1:0]   inst_adr,
  input  logic [DATA_WIDTH-1:0]   inst_dat_w,
  input  logic [DATA_WIDTH/8-1:0] inst_sel,
  output logic                    inst_ack,
  output logic                    inst_err,
  output logic [DATA_WIDTH-1:0]   inst_dat_r,

  input  logic                    data_cyc,
  input  logic                    data_stb,
  input  logic                    data_we,
  input  logic [ADDR_WIDTH-1:0]   data_adr,
  input  logic [DATA_WIDTH-1:0]   data_dat_w,
  input  logic [DATA_WIDTH/8-1:0] data_sel,
  output logic                    data_ack,
  output logic                    data_err,
  output logic [DATA_WIDTH-1:0]   data_dat_r,

  output logic                    bus_cyc,
  output logic                    bus_stb,
  output logic                    bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_adr,
  output logic [DATA_WIDTH-1:0]   bus_dat_w,
  output logic [DATA_WIDTH/8-1:0] bus_sel,
  input  logic                    bus_ack,
  input  logic                    bus_err,
  input  logic [DATA_WIDTH-1:0]   bus_dat_r,

  output logic [1:0]              grant,
  output logic                    timeout_pulse
);

  // Encoding doubles as the grant vector.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GNT_INST = 2'b01,
    GNT_DATA = 2'b10
  } state_t;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMER_WIDTH-1:0] TC_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  logic                   last_data;  // 1: data master owned the bus last
  logic [TIMER_WIDTH-1:0] timer;
  logic                   force_err;
  logic                   entered;    // first cycle after a grant edge
  logic                   own_cyc;
  logic                   own_stb;
  logic                   waiting;
  logic                   fire;

  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    bus_we    = 1'b0;
    bus_adr   = '0;
    bus_dat_w = '0;
    bus_sel   = '0;
    case (state)
      GNT_INST: begin
        own_cyc   = inst_cyc;
        own_stb   = inst_stb;
        bus_we    = inst_we;
        bus_adr   = inst_adr;
        bus_dat_w = inst_dat_w;
        bus_sel   = inst_sel;
      end
      GNT_DATA: begin
        own_cyc   = data_cyc;
        own_stb   = data_stb;
        bus_we    = data_we;
        bus_adr   = data_adr;
        bus_dat_w = data_dat_w;
        bus_sel   = data_sel;
      end
      default: ;
    endcase
  end

  assign bus_cyc = own_cyc;
  assign bus_stb = own_stb & ~force_err;

  // A same-cycle ack overrides the forced error.
  assign fire          = force_err & ~bus_ack;
  assign timeout_pulse = fire;

  assign inst_ack   = (state == GNT_INST) & bus_ack;
  assign inst_err   = (state == GNT_INST) & (bus_err | fire);
  assign inst_dat_r = (state == GNT_INST) ? bus_dat_r : '0;
  assign data_ack   = (state == GNT_DATA) & bus_ack;
  assign data_err   = (state == GNT_DATA) & (bus_err | fire);
  assign data_dat_r = (state == GNT_DATA) ? bus_dat_r : '0;

  assign grant = state;

  // The grant cycle itself is not counted, so a beat that starts with the
  // grant gets TIMEOUT_CYCLES full waiting cycles after it.
  assign waiting = own_cyc & bus_stb & ~bus_ack & ~bus_err & ~entered;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_data <= 1'b1;
      timer     <= '0;
      force_err <= 1'b0;
      entered   <= 1'b0;
    end else begin
      force_err <= 1'b0;
      entered   <= 1'b0;

      case (state)
        IDLE: begin
          if (inst_cyc && (!data_cyc || last_data)) begin
            state   <= GNT_INST;
            entered <= 1'b1;
          end else if (data_cyc) begin
            state   <= GNT_DATA;
            entered <= 1'b1;
          end
        end
        GNT_INST: begin
          if (!inst_cyc) begin
            last_data <= 1'b0;
            entered   <= data_cyc;
            state     <= data_cyc ? GNT_DATA : IDLE;
          end
        end
        GNT_DATA: begin
          if (!data_cyc) begin
            last_data <= 1'b1;
            entered   <= inst_cyc;
            state     <= inst_cyc ? GNT_INST : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // own_cyc high means the owner keeps the bus across this edge.
      if (TO_EN && waiting) begin
        if (timer == TC_LAST) begin
          force_err <= 1'b1;
          timer     <= '0;
        end else begin
          timer <= timer + TIMER_WIDTH'(1);
        end
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_copperv_wb_arbiter.sv
module tb_copperv_wb_arbiter;

  localparam int TO = 8;
  localparam int TW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        inst_cyc, inst_stb, inst_we;
  logic [31:0] inst_adr, inst_dat_w;
  logic [3:0]  inst_sel;
  logic        inst_ack, inst_err;
  logic [31:0] inst_dat_r;

  logic        data_cyc, data_stb, data_we;
  logic [31:0] data_adr, data_dat_w;
  logic [3:0]  data_sel;
  logic        data_ack, data_err;
  logic [31:0] data_dat_r;

  logic        bus_cyc, bus_stb, bus_we;
  logic [31:0] bus_adr, bus_dat_w;
  logic [3:0]  bus_sel;
  logic        bus_ack, bus_err;
  logic [31:0] bus_dat_r;

  logic [1:0]  grant;
  logic        timeout_pulse;

  always #5 clk = ~clk;

  copperv_wb_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .TIMER_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_cyc(inst_cyc), .inst_stb(inst_stb), .inst_we(inst_we),
    .inst_adr(inst_adr), .inst_dat_w(inst_dat_w), .inst_sel(inst_sel),
    .inst_ack(inst_ack), .inst_err(inst_err), .inst_dat_r(inst_dat_r),
    .data_cyc(data_cyc), .data_stb(data_stb), .data_we(data_we),
    .data_adr(data_adr), .data_dat_w(data_dat_w), .data_sel(data_sel),
    .data_ack(data_ack), .data_err(data_err), .data_dat_r(data_dat_r),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_adr(bus_adr), .bus_dat_w(bus_dat_w), .bus_sel(bus_sel),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_dat_r(bus_dat_r),
    .grant(grant), .timeout_pulse(timeout_pulse)
  );

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  typedef struct {
    logic [1:0]  g;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dw;
  } beat_t;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } resp_t;

  beat_t exp_beats[$];
  resp_t exp_inst[$];
  resp_t exp_data[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic exp_beat(input logic [1:0] g, input logic we, input logic [31:0] adr,
                          input logic [3:0] sel, input logic [31:0] dw);
    beat_t b;
    b.g = g; b.we = we; b.adr = adr; b.sel = sel; b.dw = dw;
    exp_beats.push_back(b);
  endtask

  task automatic exp_resp(input bit is_data, input logic err, input logic [31:0] dat);
    resp_t r;
    r.err = err; r.dat = dat;
    if (is_data) exp_data.push_back(r);
    else         exp_inst.push_back(r);
  endtask

  // ---------------- slave model ----------------
  int slave_delay = 2;
  bit slave_never = 1'b0;
  bit spurious    = 1'b0;

  initial begin
    int  sw;
    bit  sbusy;
    sw = 0; sbusy = 1'b0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_dat_r = '0;
    forever begin
      @(posedge clk); #2;
      if (spurious) begin
        bus_ack   = 1'b1;
        bus_dat_r = 32'hFFFF_FFFF;
      end else if (rst || !bus_cyc || bus_ack) begin
        bus_ack = 1'b0; bus_dat_r = '0; sw = 0; sbusy = 1'b0;
      end else if (sbusy || bus_stb) begin
        sbusy = 1'b1;
        if (!slave_never && sw == slave_delay) begin
          bus_ack   = 1'b1;
          bus_dat_r = (bus_adr == 32'h100) ? 32'h13 : bus_adr + 32'h1000_0000;
        end else begin
          sw++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit    prev_pend;
    beat_t b;
    resp_t r;
    prev_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pend = 1'b0;
      end else begin
        if (timeout_pulse) pulses++;
        if (bus_cyc && bus_stb && !prev_pend) begin
          if (exp_beats.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat_unexpected: got adr 0x%0h want no beat", bus_adr);
          end else begin
            b = exp_beats.pop_front();
            chk("bus_beat", {grant, bus_we, bus_adr, bus_sel, bus_dat_w},
                {b.g, b.we, b.adr, b.sel, b.dw});
          end
        end
        prev_pend = bus_cyc & bus_stb & ~bus_ack & ~bus_err;
        if (inst_ack || inst_err) begin
          if (exp_inst.size() == 0) begin
            checks++; errors++;
            $display("FAIL inst_resp_unexpected: got ack=%0b err=%0b want none", inst_ack, inst_err);
          end else begin
            r = exp_inst.pop_front();
            chk("inst_resp", {inst_ack, inst_err, inst_dat_r}, {~r.err, r.err, r.dat});
          end
          chk("inst_resp_data_quiet", {data_ack, data_err, data_dat_r}, 0);
        end
        if (data_ack || data_err) begin
          if (exp_data.size() == 0) begin
            checks++; errors++;
            $display("FAIL data_resp_unexpected: got ack=%0b err=%0b want none", data_ack, data_err);
          end else begin
            r = exp_data.pop_front();
            chk("data_resp", {data_ack, data_err, data_dat_r}, {~r.err, r.err, r.dat});
          end
          chk("data_resp_inst_quiet", {inst_ack, inst_err, inst_dat_r}, 0);
        end
      end
    end
  end

  // ---------------- master helpers ----------------
  task automatic drive(input bit is_data, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dw);
    if (is_data) begin
      data_cyc = cyc; data_stb = stb; data_we = we;
      data_adr = adr; data_sel = sel; data_dat_w = dw;
    end else begin
      inst_cyc = cyc; inst_stb = stb; inst_we = we;
      inst_adr = adr; inst_sel = sel; inst_dat_w = dw;
    end
  endtask

  task automatic do_xfer(input bit is_data, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dw, input int nbeats);
    logic [31:0] a;
    bit got;
    a = adr;
    drive(is_data, 1'b1, 1'b1, we, a, sel, dw);
    for (int i = 0; i < nbeats; i++) begin
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        got = is_data ? (data_ack | data_err) : (inst_ack | inst_err);
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL xfer_no_response: got none want ack/err at adr 0x%0h", a);
      end
      @(posedge clk); #1;
      a = a + 32'd4;
      if (i == nbeats - 1) drive(is_data, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      else                 drive(is_data, 1'b1, 1'b1, we, a, sel, dw);
    end
  endtask

  // Both masters request a single read in the same cycle: inst must win,
  // and data must follow with no idle cycle between the two grants.
  task automatic tie_test(input logic [31:0] ai, input logic [31:0] ad,
                          input logic [31:0] ri, input logic [31:0] rd, input string nm);
    exp_beat(2'b01, 1'b0, ai, 4'hF, '0);
    exp_beat(2'b10, 1'b0, ad, 4'hF, '0);
    exp_resp(1'b0, 1'b0, ri);
    exp_resp(1'b1, 1'b0, rd);
    fork
      do_xfer(1'b0, 1'b0, ai, 4'hF, '0, 1);
      do_xfer(1'b1, 1'b0, ad, 4'hF, '0, 1);
      begin
        int c;
        c = 0;
        do begin @(negedge clk); c++; end while (grant == 2'b00 && c < 20);
        chk({nm, "_first_grant"}, grant, 2'b01);
        c = 0;
        do begin @(negedge clk); c++; end while (grant == 2'b01 && c < 20);
        chk({nm, "_handover"}, grant, 2'b10);
      end
    join
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h55, 4'hF, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1 rst = 1'b1;
    #1;
    chk("reset_ctrl", {bus_cyc, bus_stb, bus_we, grant, timeout_pulse}, 0);
    chk("reset_bus_fields", {bus_adr, bus_sel, bus_dat_w}, 0);
    chk("reset_resp", {inst_ack, inst_err, data_ack, data_err, inst_dat_r, data_dat_r}, 0);
    repeat (2) @(negedge clk);
    chk("reset_holds_idle", {bus_cyc, grant}, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Single instruction fetch, slave acks two cycles after stb.
    exp_beat(2'b01, 1'b0, 32'h100, 4'hF, '0);
    exp_resp(1'b0, 1'b0, 32'h0000_0013);
    fork
      do_xfer(1'b0, 1'b0, 32'h100, 4'hF, '0, 1);
      begin
        @(negedge clk);
        chk("t1_no_bus_before_grant", {bus_cyc, grant}, 0);
        @(negedge clk);
        chk("t1_grant_latency", {bus_cyc, bus_stb, grant}, {1'b1, 1'b1, 2'b01});
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Round-robin ties.
    pulse_reset();
    tie_test(32'h200, 32'h300, 32'h1000_0200, 32'h1000_0300, "t2_tie_after_reset");
    tie_test(32'h240, 32'h340, 32'h1000_0240, 32'h1000_0340, "t2_tie_repeat");

    // Data write waits behind a three-beat instruction burst.
    exp_beat(2'b01, 1'b0, 32'h400, 4'hF, '0);
    exp_beat(2'b01, 1'b0, 32'h404, 4'hF, '0);
    exp_beat(2'b01, 1'b0, 32'h408, 4'hF, '0);
    exp_beat(2'b10, 1'b1, 32'h2004, 4'b0011, 32'hBEEF);
    exp_resp(1'b0, 1'b0, 32'h1000_0400);
    exp_resp(1'b0, 1'b0, 32'h1000_0404);
    exp_resp(1'b0, 1'b0, 32'h1000_0408);
    exp_resp(1'b1, 1'b0, 32'h1000_2004);
    fork
      do_xfer(1'b0, 1'b0, 32'h400, 4'hF, '0, 3);
      begin
        @(posedge clk); #1;
        do_xfer(1'b1, 1'b1, 32'h2004, 4'b0011, 32'hBEEF, 1);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Ack while idle must not reach either master.
    spurious = 1'b1;
    @(negedge clk);
    chk("idle_spurious_ack_dropped",
        {bus_cyc, inst_ack, inst_err, data_ack, data_err, inst_dat_r, data_dat_r, timeout_pulse}, 0);
    @(posedge clk); #1;
    spurious = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Hung slave: forced err nine cycles after stb rises.
    slave_never = 1'b1;
    exp_beat(2'b10, 1'b0, 32'h600, 4'hF, '0);
    exp_resp(1'b1, 1'b1, 32'h0);
    fork
      do_xfer(1'b1, 1'b0, 32'h600, 4'hF, '0, 1);
      begin
        int  n;
        bit  got;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = bus_stb; end
        n = 0; got = 1'b0;
        while (n < 30 && !got) begin @(negedge clk); n++; got = data_err; end
        chk("t4_err_latency", n, 9);
        chk("t4_force_cycle", {timeout_pulse, bus_stb, grant}, {1'b1, 1'b0, 2'b10});
        @(negedge clk);
        chk("t4_grant_retained", {timeout_pulse, grant}, {1'b0, 2'b10});
        @(negedge clk);
        chk("t4_released", grant, 2'b00);
      end
    join
    slave_never = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Ack lands in the very cycle the timeout would fire.
    slave_delay = 9;
    exp_beat(2'b10, 1'b0, 32'h700, 4'hF, '0);
    exp_resp(1'b1, 1'b0, 32'h1000_0700);
    fork
      do_xfer(1'b1, 1'b0, 32'h700, 4'hF, '0, 1);
      begin
        int  n;
        bit  got;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = bus_stb; end
        n = 0; got = 1'b0;
        while (n < 30 && !got) begin @(negedge clk); n++; got = data_ack | data_err; end
        chk("t5_ack_latency", n, 9);
        chk("t5_ack_wins", {data_ack, data_err, timeout_pulse}, {1'b1, 1'b0, 1'b0});
      end
    join
    slave_delay = 2;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a beat.
    slave_delay = 6;
    exp_beat(2'b01, 1'b0, 32'h800, 4'hF, '0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h800, 4'hF, '0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_granted_before_reset", {bus_cyc, grant}, {1'b1, 2'b01});
    #2 rst = 1'b1;
    #1;
    chk("t6_async_reset_immediate",
        {bus_cyc, bus_stb, grant, inst_ack, inst_err, data_ack, data_err, timeout_pulse}, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk) rst = 1'b0;
    slave_delay = 2;
    @(posedge clk); #1;
    tie_test(32'h900, 32'hA00, 32'h1000_0900, 32'h1000_0A00, "t6_tie_after_reset");

    repeat (3) @(negedge clk);
    chk("queues_drained", {exp_beats.size(), exp_inst.size(), exp_data.size()}, 0);
    chk("timeout_pulse_count", pulses, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
